// File: rtl/pingpong_filler.sv
// pingpong_filler: streams producer words into the active half of a ping-pong
// buffer, then swaps halves when a half is full or a flush is requested. The
// swap is held off while the consumer still owns the previously swapped half.
// Optional feature: define PINGPONG_FILLER_OVERRUN_COUNT_EN to add the 16-bit
// saturating overrunCount output (cycles where the producer was stalled).
module pingpong_filler #(
  parameter int FILL_LIMIT = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] dataIn,
  input  logic        dataValid,
  output logic        dataReady,
  input  logic        flush,
  output logic [8:0]  bufferAddress,
  output logic [31:0] bufferDataOut,
  output logic        bufferWriteEnable,
  output logic        bufferSwitch,
  output logic        blockReady,
  output logic [8:0]  blockLength,
  input  logic        consumerDone
`ifdef PINGPONG_FILLER_OVERRUN_COUNT_EN
  ,
  output logic [15:0] overrunCount
`endif
);

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_SWAP  = 2'd2,
    ST_WAIT  = 2'd3
  } state_t;

  localparam logic [8:0] LIMIT = 9'(FILL_LIMIT);

  state_t      state_reg;
  state_t      state_next;
  logic [8:0]  wr_ptr_reg;
  logic [8:0]  wr_ptr_inc;
  logic [8:0]  buf_addr_reg;
  logic [31:0] buf_data_reg;
  logic        buf_we_reg;
  logic        block_ready_reg;
  logic [8:0]  block_length_reg;
  logic        data_ready;
  logic        buffer_switch;
  logic        accept;
  logic        swap_req;

  assign accept     = dataValid & data_ready;
  assign wr_ptr_inc = wr_ptr_reg + 9'd1;

  // A swap is due when this acceptance fills the half, or on a flush while the
  // half holds at least one word (counting a word accepted in the same cycle).
  assign swap_req = accept ? ((wr_ptr_inc == LIMIT) | flush)
                           : (flush & (wr_ptr_reg != 9'd0));

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_FILL;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic. DRAIN lets the final write strobe reach the buffer
  // before any switch; a consumerDone arriving in DRAIN releases the old half
  // directly, otherwise that pulse would be consumed and WAIT would never exit.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_FILL:  if (swap_req) state_next = ST_DRAIN;
      ST_DRAIN: state_next = (!block_ready_reg || consumerDone) ? ST_SWAP : ST_WAIT;
      ST_WAIT:  if (consumerDone) state_next = ST_SWAP;
      ST_SWAP:  state_next = ST_FILL;
      default:  state_next = ST_FILL;
    endcase
  end

  // State-decoded outputs: ready only while filling, switch only in SWAP.
  always_comb begin
    data_ready    = 1'b0;
    buffer_switch = 1'b0;
    case (state_reg)
      ST_FILL: data_ready    = 1'b1;
      ST_SWAP: buffer_switch = 1'b1;
      default: ;
    endcase
  end

  // Write pointer and registered buffer write port (one cycle after accept).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg   <= 9'd0;
      buf_addr_reg <= 9'd0;
      buf_data_reg <= 32'd0;
      buf_we_reg   <= 1'b0;
    end else begin
      buf_we_reg <= accept;
      if (accept) begin
        buf_addr_reg <= {1'b0, wr_ptr_reg[7:0]};
        buf_data_reg <= dataIn;
      end
      if (state_reg == ST_SWAP) begin
        wr_ptr_reg <= 9'd0;
      end else if (accept) begin
        wr_ptr_reg <= wr_ptr_inc;
      end
    end
  end

  // Hand-off to the consumer: SWAP publishes the half and wins over a
  // coincident consumerDone; otherwise consumerDone releases the half.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      block_ready_reg  <= 1'b0;
      block_length_reg <= 9'd0;
    end else if (state_reg == ST_SWAP) begin
      block_ready_reg  <= 1'b1;
      block_length_reg <= wr_ptr_reg;
    end else if (consumerDone) begin
      block_ready_reg  <= 1'b0;
    end
  end

`ifdef PINGPONG_FILLER_OVERRUN_COUNT_EN
  logic [15:0] overrun_cnt_reg;

  // Count stalled producer cycles, saturating at all-ones.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overrun_cnt_reg <= 16'd0;
    end else if (dataValid && !data_ready && (overrun_cnt_reg != 16'hFFFF)) begin
      overrun_cnt_reg <= overrun_cnt_reg + 16'd1;
    end
  end

  assign overrunCount = overrun_cnt_reg;
`endif

  assign dataReady         = data_ready;
  assign bufferSwitch      = buffer_switch;
  assign bufferAddress     = buf_addr_reg;
  assign bufferDataOut     = buf_data_reg;
  assign bufferWriteEnable = buf_we_reg;
  assign blockReady        = block_ready_reg;
  assign blockLength       = block_length_reg;

endmodule
